ccd_readout_sequencer: RTL
==========================

Name: ccd_readout_sequencer

Overview:
Frame-level controller for signal_generator. Holds the exposure and readout geometry in Wishbone registers. Drives the generator's enable and f_select inputs, and counts pixel-reset pulses (phi_r) to sequence one frame: expose, then read LINES lines of PIXELS pixels with an idle gap between lines. Sits on the same Wishbone bus as signal_generator, in a separate address window.

Parameters:
BASE_ADDR, 32'h3000_0100, base address of the register window.
LINE_GAP, 16, i_wb_clk cycles that o_sg_enable is held low between lines.
RST_FSEL, 4'b0000, reset value of the FSEL register.

Ports:
i_wb_clk  in  1  system clock; the only clock.
i_wb_rst_n  in  1  asynchronous, active-low reset.
i_wb_cyc  in  1  Wishbone cycle.
i_wb_stb  in  1  Wishbone strobe.
i_wb_we  in  1  Wishbone write enable.
i_wb_addr  in  32  Wishbone address.
i_wb_data  in  32  Wishbone write data.
o_wb_ack  out  1  Wishbone acknowledge.
o_wb_data  out  32  Wishbone read data.
i_phi_r  in  1  phi_r from signal_generator; asynchronous to i_wb_clk.
o_sg_enable  out  1  to signal_generator i_enable_gpio.
o_sg_f_select  out  4  to signal_generator i_f_select_gpio.
o_irq  out  1  frame-done interrupt, level, sticky.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL, write-only: bit0 START, bit1 ABORT, bit2 IRQ_CLR. Bits are self-clearing pulses; reads return 0.
  - 0x04 EXPOSURE, R/W, 32 bit, in i_wb_clk cycles.
  - 0x08 PIXELS, R/W, [15:0].
  - 0x0C LINES, R/W, [15:0].
  - 0x10 FSEL, R/W, [3:0].
  - 0x14 STATUS, RO: [2:0] state code, [3] busy, [4] done.
  - 0x18 COUNT, RO: {line_cnt[15:0], pix_cnt[15:0]}.
- Wishbone handshake:
  - o_wb_ack is a 1-cycle pulse, registered, asserted the cycle after i_wb_cyc & i_wb_stb & !o_wb_ack.
  - One ack per access.
  - Unmapped offsets inside the window ack and read 0; writes to them are ignored.
  - Addresses outside the window produce no ack.
  - o_wb_data is valid on the ack cycle and 0 otherwise.
- Writes to EXPOSURE, PIXELS, LINES and FSEL are ignored while busy.
- Reset values: all registers 0 except FSEL = RST_FSEL; state IDLE; o_sg_enable=0; o_sg_f_select=RST_FSEL; o_irq=0; o_wb_ack=0; o_wb_data=0.
- i_phi_r path: 2-flop synchronizer, then a rising-edge detect, giving pix_pulse with 3-cycle latency.
- o_sg_f_select = FSEL register, registered.
- FSM states, code in brackets:
  - IDLE(0): o_sg_enable=0. START with PIXELS!=0 and LINES!=0 → EXPOSE; counters cleared, done cleared. START with PIXELS=0 or LINES=0 → DONE immediately.
  - EXPOSE(1): down-counter loaded with EXPOSURE, decremented each cycle. At 0 → READ. EXPOSURE=0 gives 1 cycle in EXPOSE.
  - READ(2): o_sg_enable=1. Each pix_pulse increments pix_cnt. When pix_cnt reaches PIXELS: pix_cnt←0, line_cnt+1. If line_cnt+1==LINES → DONE, else → GAP.
  - GAP(3): o_sg_enable=0 for LINE_GAP cycles, then → READ.
  - DONE(4): o_sg_enable=0; done=1; o_irq=1. Next cycle → IDLE. done and o_irq stay set until IRQ_CLR or the next START.
- busy = state in {EXPOSE, READ, GAP}.
- START while busy is ignored.
- ABORT in any busy state: next cycle IDLE and o_sg_enable=0; done and o_irq are not set; counters hold their values for debug.
- ABORT and START in the same write: ABORT wins.
- IRQ_CLR together with entry to DONE: set wins.
- pix_pulse in GAP, EXPOSE or IDLE is ignored.
- Counters are 16 bit; they cannot wrap because compares are against registers of equal width.
- Reset mid-frame: immediate return to reset values; generator disabled asynchronously.

Optional Feature:
Macro CCD_SEQ_CONTINUOUS_EN.
- Defined:
  - CTRL bit3 CONT is a sticky R/W bit, readable at CTRL bit3.
  - If CONT=1, DONE → EXPOSE instead of IDLE, restarting the frame with cleared counters. o_irq still pulses its sticky set.
  - A frame counter [15:0] is readable at 0x1C, incremented on each DONE and cleared by START.
  - ABORT also clears CONT.
- Not defined: bit3 is ignored and reads 0; 0x1C reads 0; DONE → IDLE always.

Test Plan:
- Reset with i_wb_rst_n=0 mid-READ → o_sg_enable=0, o_irq=0, STATUS=0, o_sg_f_select=RST_FSEL, asynchronously without a clock edge.
- Write EXPOSURE=10, PIXELS=4, LINES=2, FSEL=8; START; 4 phi_r pulses, then 4 more after the gap.
  - EXPOSE lasts 10 cycles.
  - o_sg_enable high in each READ and low for 16 cycles in the GAP.
  - DONE follows the 8th pulse.
  - o_irq=1, STATUS=0x10, COUNT=0x0002_0000, o_sg_f_select=8.
- ABORT issued after 2 pixels of line 0 → IDLE next cycle, o_sg_enable=0, o_irq=0, COUNT=0x0000_0002.
- START with PIXELS=0 → DONE then IDLE, o_irq=1, o_sg_enable never asserted.
- Register access:
  - Each access gets exactly one ack cycle.
  - Write to PIXELS while busy is ignored; read back returns the old value.
  - Read of offset 0x20 returns 0 with ack.
  - Address BASE_ADDR+0x100 gets no ack.
- With CCD_SEQ_CONTINUOUS_EN: CONT=1, PIXELS=1, LINES=1 → 3 frames back-to-back, 0x1C reads 3. ABORT → IDLE, CTRL bit3 reads 0.

Source files
------------

// File: rtl/ccd_readout_sequencer_if.sv
// Wishbone slave bus bundle for ccd_readout_sequencer; names follow the slave's view.
interface ccd_readout_sequencer_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_data;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      input  o_wb_ack, o_wb_data
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
      output o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/ccd_readout_sequencer.sv
// Frame sequencer for signal_generator: expose, then read LINES x PIXELS counted on phi_r.
// Optional continuous-frame mode is built in when CCD_SEQ_CONTINUOUS_EN is defined.
module ccd_readout_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
   parameter int unsigned LINE_GAP  = 16,
   parameter logic [3:0]  RST_FSEL  = 4'b0000
) (
   input  logic                          i_wb_clk,
   input  logic                          i_wb_rst_n,
   ccd_readout_sequencer_if.slave        wb,
   input  logic                          i_phi_r,
   output logic                          o_sg_enable,
   output logic [3:0]                    o_sg_f_select,
   output logic                          o_irq
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StExpose = 3'd1,
      StRead   = 3'd2,
      StGap    = 3'd3,
      StDone   = 3'd4
   } state_e;

   localparam logic [15:0] GapLast = 16'(LINE_GAP - 1);

   state_e      r_state, w_state_d;
   logic        r_ack;
   logic [31:0] r_rdata, w_rd_mux;
   logic [31:0] r_exposure, r_exp_cnt, w_exp_cnt_d;
   logic [15:0] r_pixels, r_lines;
   logic [3:0]  r_fsel, r_fsel_out;
   logic [15:0] r_pix_cnt, w_pix_cnt_d, r_line_cnt, w_line_cnt_d, r_gap_cnt, w_gap_cnt_d;
   logic [15:0] w_pix_inc, w_line_inc;
   logic        r_done, w_done_d, r_sg_enable;
   logic        r_phi_meta, r_phi_sync, r_phi_prev, r_pix_pulse;
   logic        w_hit, w_acc, w_wr, w_ctrl_wr, w_cfg_wr;
   logic        w_start, w_abort, w_irq_clr, w_busy, w_go, w_valid_geom, w_set_done;
   logic [7:0]  w_off;
   logic        w_cont;
`ifdef CCD_SEQ_CONTINUOUS_EN
   logic        r_cont;
   logic [15:0] r_frame_cnt, w_frame_cnt_d;
`endif

   // Bus decode: the window spans 256 bytes above BASE_ADDR
   assign w_hit     = (wb.i_wb_addr[31:8] == BASE_ADDR[31:8]);
   assign w_acc     = wb.i_wb_cyc & wb.i_wb_stb & ~r_ack & w_hit;
   assign w_wr      = w_acc & wb.i_wb_we;
   assign w_off     = wb.i_wb_addr[7:0];
   assign w_ctrl_wr = w_wr & (w_off == 8'h00);
   assign w_start   = w_ctrl_wr & wb.i_wb_data[0];
   assign w_abort   = w_ctrl_wr & wb.i_wb_data[1];
   assign w_irq_clr = w_ctrl_wr & wb.i_wb_data[2];
   assign w_busy    = (r_state == StExpose) | (r_state == StRead) | (r_state == StGap);
   assign w_cfg_wr  = w_wr & ~w_busy;
   assign w_go      = w_start & ~w_abort & ~w_busy;
   assign w_valid_geom = (r_pixels != 16'd0) & (r_lines != 16'd0);
   assign w_pix_inc  = r_pix_cnt + 16'd1;
   assign w_line_inc = r_line_cnt + 16'd1;

`ifdef CCD_SEQ_CONTINUOUS_EN
   assign w_cont = r_cont;
`else
   assign w_cont = 1'b0;
`endif

   always_comb begin
      w_rd_mux = '0;
      case (w_off)
         8'h00:   w_rd_mux = {28'd0, w_cont, 3'd0};
         8'h04:   w_rd_mux = r_exposure;
         8'h08:   w_rd_mux = {16'd0, r_pixels};
         8'h0C:   w_rd_mux = {16'd0, r_lines};
         8'h10:   w_rd_mux = {28'd0, r_fsel};
         8'h14:   w_rd_mux = {27'd0, r_done, w_busy, r_state};
         8'h18:   w_rd_mux = {r_line_cnt, r_pix_cnt};
`ifdef CCD_SEQ_CONTINUOUS_EN
         8'h1C:   w_rd_mux = {16'd0, r_frame_cnt};
`endif
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= w_acc;
         r_rdata <= (w_acc && !wb.i_wb_we) ? w_rd_mux : '0;
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_exposure <= '0;
         r_pixels   <= '0;
         r_lines    <= '0;
         r_fsel     <= RST_FSEL;
         r_fsel_out <= RST_FSEL;
      end else begin
         r_fsel_out <= r_fsel;
         if (w_cfg_wr) begin
            case (w_off)
               8'h04:   r_exposure <= wb.i_wb_data;
               8'h08:   r_pixels   <= wb.i_wb_data[15:0];
               8'h0C:   r_lines    <= wb.i_wb_data[15:0];
               8'h10:   r_fsel     <= wb.i_wb_data[3:0];
               default: ;
            endcase
         end
      end
   end

`ifdef CCD_SEQ_CONTINUOUS_EN
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_cont <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_cont <= wb.i_wb_data[3] & ~wb.i_wb_data[1];
      end
   end
`endif

   // phi_r is asynchronous: two-flop synchronizer, then a registered rising-edge pulse
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_phi_meta  <= 1'b0;
         r_phi_sync  <= 1'b0;
         r_phi_prev  <= 1'b0;
         r_pix_pulse <= 1'b0;
      end else begin
         r_phi_meta  <= i_phi_r;
         r_phi_sync  <= r_phi_meta;
         r_phi_prev  <= r_phi_sync;
         r_pix_pulse <= r_phi_sync & ~r_phi_prev;
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_exp_cnt_d  = r_exp_cnt;
      w_pix_cnt_d  = r_pix_cnt;
      w_line_cnt_d = r_line_cnt;
      w_gap_cnt_d  = r_gap_cnt;
      w_done_d     = r_done & ~w_irq_clr;
      if (w_go) begin
         w_done_d     = 1'b0;
         w_pix_cnt_d  = '0;
         w_line_cnt_d = '0;
         w_exp_cnt_d  = r_exposure;
         w_state_d    = w_valid_geom ? StExpose : StDone;
      end else begin
         unique case (r_state)
            StExpose: begin
               if (w_abort) begin
                  w_state_d = StIdle;
               end else if (r_exp_cnt <= 32'd1) begin
                  w_state_d = StRead;
               end else begin
                  w_exp_cnt_d = r_exp_cnt - 32'd1;
               end
            end
            StRead: begin
               if (w_abort) begin
                  w_state_d = StIdle;
               end else if (r_pix_pulse) begin
                  if (w_pix_inc == r_pixels) begin
                     w_pix_cnt_d  = '0;
                     w_line_cnt_d = w_line_inc;
                     w_gap_cnt_d  = '0;
                     w_state_d    = (w_line_inc == r_lines) ? StDone : StGap;
                  end else begin
                     w_pix_cnt_d = w_pix_inc;
                  end
               end
            end
            StGap: begin
               if (w_abort) begin
                  w_state_d = StIdle;
               end else if (r_gap_cnt == GapLast) begin
                  w_state_d = StRead;
               end else begin
                  w_gap_cnt_d = r_gap_cnt + 16'd1;
               end
            end
            StDone: begin
               if (w_cont) begin
                  w_pix_cnt_d  = '0;
                  w_line_cnt_d = '0;
                  w_exp_cnt_d  = r_exposure;
                  w_state_d    = StExpose;
               end else begin
                  w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
      // Entry to DONE overrides a simultaneous IRQ_CLR
      if (w_set_done) begin
         w_done_d = 1'b1;
      end
   end

   assign w_set_done = (w_state_d == StDone);

`ifdef CCD_SEQ_CONTINUOUS_EN
   always_comb begin
      w_frame_cnt_d = w_go ? 16'd0 : r_frame_cnt;
      if (w_set_done) begin
         w_frame_cnt_d = w_frame_cnt_d + 16'd1;
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_frame_cnt <= '0;
      end else begin
         r_frame_cnt <= w_frame_cnt_d;
      end
   end
`endif

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_state     <= StIdle;
         r_exp_cnt   <= '0;
         r_pix_cnt   <= '0;
         r_line_cnt  <= '0;
         r_gap_cnt   <= '0;
         r_done      <= 1'b0;
         r_sg_enable <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_exp_cnt   <= w_exp_cnt_d;
         r_pix_cnt   <= w_pix_cnt_d;
         r_line_cnt  <= w_line_cnt_d;
         r_gap_cnt   <= w_gap_cnt_d;
         r_done      <= w_done_d;
         r_sg_enable <= (w_state_d == StRead);
      end
   end

   assign wb.o_wb_ack   = r_ack;
   assign wb.o_wb_data  = r_rdata;
   assign o_sg_enable   = r_sg_enable;
   assign o_sg_f_select = r_fsel_out;
   assign o_irq         = r_done;

endmodule
